// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and defaults for the CPU run controller (state encoding, output flags).
// The watchdog is built only when CPU_RUN_CTRL_WATCHDOG_EN is defined.
package cpu_run_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT        = 32;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;
  localparam int unsigned TIMEOUT_DEFAULT      = 100000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  // Registered single-bit controls driven towards the CPU and the harness
  typedef struct packed {
    logic cpu_en;
    logic dump_req;
    logic done;
    logic timeout;
  } run_flags_t;

  // Drain counter width: must hold DRAIN_CYCLES-1, at least one bit
  function automatic int unsigned drain_width(input int unsigned drain_cycles);
    return (drain_cycles > 1) ? $clog2(drain_cycles) : 1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for cycle and write counts.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  // Clear has priority over increment; holds at all ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: starts/gates the MIPS core, counts cycles and writes, drains after halt,
// then requests dumps and reports done. Watchdog built only with CPU_RUN_CTRL_WATCHDOG_EN.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             dmem_mem_write,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] mem_wr_count,
  output logic             dump_req,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned DRN_W      = drain_width(DRAIN_CYCLES);
  localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;

  run_state_e       state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  run_flags_t       flags_q, flags_d;

  logic start_ok;
  logic timeout_set;
  logic cyc_en;
  logic wr_en;
  logic wd_hit;

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
  // Fires on the enabled RUN cycle that brings cycle_count up to TIMEOUT
  assign wd_hit = ((64'(cycle_count) + 64'd1) >= 64'(TIMEOUT));
`else
  assign wd_hit = 1'b0;
`endif

  // State, drain counter and output flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      flags_q <= flags_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    flags_d     = '0;
    start_ok    = 1'b0;
    timeout_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_RUN;
        end
      end

      // First RUN cycle only raises cpu_en; halt is looked at once the core is enabled
      ST_RUN: begin
        flags_d.cpu_en = 1'b1;
        if (flags_q.cpu_en) begin
          if (halt) begin
            if (DRAIN_CYCLES == 0) begin
              state_d        = ST_DUMP;
              flags_d.cpu_en = 1'b0;
            end else begin
              state_d = ST_DRAIN;
              drain_d = DRN_W'(DRAIN_LOAD);
            end
          end else if (wd_hit) begin
            state_d        = ST_DUMP;
            flags_d.cpu_en = 1'b0;
            timeout_set    = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DUMP;
        end else begin
          flags_d.cpu_en = 1'b1;
          drain_d        = drain_q - DRN_W'(1);
        end
      end

      ST_DUMP: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    flags_d.dump_req = (state_q == ST_DUMP);
    flags_d.done     = (state_q == ST_DONE) && (state_d == ST_DONE);

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    if (start_ok) begin
      flags_d.timeout = 1'b0;
    end else begin
      flags_d.timeout = flags_q.timeout | timeout_set;
    end
`else
    flags_d.timeout = 1'b0;
`endif
  end

  // Cycle count stops at the halt cycle; write count keeps going through drain
  assign cyc_en = flags_q.cpu_en && (state_q == ST_RUN);
  assign wr_en  = flags_q.cpu_en && dmem_mem_write;

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (cyc_en),
    .count (cycle_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (wr_en),
    .count (mem_wr_count)
  );

  assign cpu_en   = flags_q.cpu_en;
  assign dump_req = flags_q.dump_req;
  assign done     = flags_q.done;
  assign timeout  = flags_q.timeout;

endmodule
